// File: rtl/interval_scheduler_pkg.sv
// Shared constants and FSM state encoding for the interval scheduler.
package interval_scheduler_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int CNT_WIDTH_DEF = 4;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_CLEAR_ENC = 2'd1;
    localparam logic [1:0] ST_RUN_ENC   = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_CLEAR = ST_CLEAR_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/interval_scheduler_counter.sv
// Shared interval up-counter: synchronous clear has priority over enable.
module interval_counter
    import interval_scheduler_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 rst_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: increment when enabled, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clock) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/interval_scheduler.sv
// Round-robin arbiter that lends one shared counter to a requester for a
// programmed number of cycles, then pulses that requester's done.
module interval_scheduler
    import interval_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]   len,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           count_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] target_q, target_d;
    logic [CNT_WIDTH-1:0] count_s;
    logic [IDX_W:0]       pick_s;
    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic                 owner_req_s;
    logic                 terminal_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [NUM_REQ-1:0]   done_s;

    // First asserted request strictly after ptr, wrapping; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0]   ptr_v);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(ptr_v) + i) % NUM_REQ);
            if (req_v[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign pick_s      = rr_pick(req, ptr_q);
    assign owner_req_s = req[owner_q];
    assign terminal_s  = (count_s == (target_q - CNT_ONE));

    // Next-state logic; a dropped owner request wins over terminal count.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        target_d  = target_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    owner_d  = pick_s[IDX_W-1:0];
                    target_d = len[int'(pick_s[IDX_W-1:0])*CNT_WIDTH +: CNT_WIDTH];
                    state_d  = ST_CLEAR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (!owner_req_s) begin
                    ptr_d     = owner_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_clr_s = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!owner_req_s) begin
                    ptr_d    = owner_q;
                    state_d  = ST_IDLE;
                end else if (terminal_s) begin
                    state_d  = ST_DONE;
                end else begin
                    cnt_en_s = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_DONE: begin
                ptr_d   = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; ptr resets to the top index so req[0] is searched first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= IDX_W'(NUM_REQ - 1);
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            target_q <= target_d;
        end
    end

    interval_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clock   (clock),
        .rst_i   (reset | cnt_clr_s),
        .en_i    (cnt_en_s),
        .count_o (count_s)
    );

    // Output decode from registered state and owner.
    always_comb begin
        grant_s = '0;
        done_s  = '0;
        if (state_q != ST_IDLE) begin
            grant_s[owner_q] = 1'b1;
        end else begin
            grant_s = '0;
        end
        if (state_q == ST_DONE) begin
            done_s[owner_q] = 1'b1;
        end else begin
            done_s = '0;
        end
    end

    assign grant     = grant_s;
    assign done      = done_s;
    assign busy      = (state_q != ST_IDLE);
    assign count_out = count_s;

endmodule

// File: tb/tb_interval_scheduler.sv
// Directed, table-driven bench for interval_scheduler (NUM_REQ=4, CNT_WIDTH=4).
module tb_interval_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count_out;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
        logic [3:0]  c;
    } vec_t;

    vec_t tbl[8];

    interval_scheduler #(
        .NUM_REQ   (4),
        .CNT_WIDTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count_out (count_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic [3:0] c);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".count"}, 32'(count_out), 32'(c));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        req   = 4'b0000;
        len   = 16'h0000;

        // Basic interval of 3; len change mid-run must be ignored.
        tbl[0] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
        tbl[1] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd0};
        tbl[2] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd0};
        tbl[3] = '{1'b0, 4'b0001, 16'h000F, 4'b0001, 4'b0000, 1'b1, 4'd1};
        tbl[4] = '{1'b0, 4'b0001, 16'h000F, 4'b0001, 4'b0000, 1'b1, 4'd2};
        tbl[5] = '{1'b0, 4'b0001, 16'h000F, 4'b0001, 4'b0001, 1'b1, 4'd2};
        tbl[6] = '{1'b0, 4'b0000, 16'h000F, 4'b0000, 4'b0000, 1'b0, 4'd2};
        tbl[7] = '{1'b0, 4'b0000, 16'h000F, 4'b0000, 4'b0000, 1'b0, 4'd2};

        for (int i = 0; i < 8; i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            len   = tbl[i].len;
            step();
            chk_all($sformatf("tbl%0d", i), tbl[i].g, tbl[i].d, tbl[i].b, tbl[i].c);
        end

        // len=0 means a 16-cycle interval; CLEAR shows the stale count.
        req = 4'b0001;
        len = 16'h0000;
        step();
        chk_all("len0.clear", 4'b0001, 4'b0000, 1'b1, 4'd2);
        for (int k = 0; k < 16; k++) begin
            step();
            chk_all($sformatf("len0.run%0d", k), 4'b0001, 4'b0000, 1'b1, 4'(k));
        end
        step();
        chk_all("len0.done", 4'b0001, 4'b0001, 1'b1, 4'd15);
        req = 4'b0000;
        step();
        chk_all("len0.idle", 4'b0000, 4'b0000, 1'b0, 4'd15);
        step();
        chk_all("len0.idle2", 4'b0000, 4'b0000, 1'b0, 4'd15);

        // All four requesting with len=1: 4-cycle rotation 0,1,2,3,0.
        reset = 1'b1;
        step();
        chk_all("rst2", 4'b0000, 4'b0000, 1'b0, 4'd0);
        reset = 1'b0;
        req   = 4'b1111;
        len   = 16'h1111;
        for (int s = 0; s < 20; s++) begin
            logic [3:0] oh;
            oh = 4'b0001 << ((s / 4) % 4);
            step();
            chk($sformatf("rr%0d.onehot", s), 32'($onehot0(grant)), 32'd1);
            case (s % 4)
                0:       chk_all($sformatf("rr%0d", s), oh, 4'b0000, 1'b1, 4'd0);
                1:       chk_all($sformatf("rr%0d", s), oh, 4'b0000, 1'b1, 4'd0);
                2:       chk_all($sformatf("rr%0d", s), oh, oh,      1'b1, 4'd0);
                default: chk_all($sformatf("rr%0d", s), 4'b0000, 4'b0000, 1'b0, 4'd0);
            endcase
        end

        // Abort: owner 0 drops its request at count 3; owner 1 follows.
        req   = 4'b0000;
        reset = 1'b1;
        step();
        chk_all("rst3", 4'b0000, 4'b0000, 1'b0, 4'd0);
        reset = 1'b0;
        req   = 4'b0011;
        len   = 16'h0028;
        step();
        chk_all("ab.clear0", 4'b0001, 4'b0000, 1'b1, 4'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("ab.run%0d", k), 4'b0001, 4'b0000, 1'b1, 4'(k));
        end
        req = 4'b0010;
        step();
        chk_all("ab.idle", 4'b0000, 4'b0000, 1'b0, 4'd3);
        step();
        chk_all("ab.clear1", 4'b0010, 4'b0000, 1'b1, 4'd3);
        step();
        chk_all("ab.run1a", 4'b0010, 4'b0000, 1'b1, 4'd0);
        step();
        chk_all("ab.run1b", 4'b0010, 4'b0000, 1'b1, 4'd1);
        step();
        chk_all("ab.done1", 4'b0010, 4'b0010, 1'b1, 4'd1);

        // Reset in the middle of RUN, then req=1100 grants 2 before 3.
        req = 4'b0000;
        step();
        chk_all("mr.idle", 4'b0000, 4'b0000, 1'b0, 4'd1);
        req = 4'b0001;
        len = 16'h0008;
        step();
        chk_all("mr.clear", 4'b0001, 4'b0000, 1'b1, 4'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_all($sformatf("mr.run%0d", k), 4'b0001, 4'b0000, 1'b1, 4'(k));
        end
        reset = 1'b1;
        step();
        chk_all("mr.reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
        reset = 1'b0;
        req   = 4'b1100;
        len   = 16'h1100;
        step();
        chk_all("mr.clear2", 4'b0100, 4'b0000, 1'b1, 4'd0);
        step();
        chk_all("mr.run2", 4'b0100, 4'b0000, 1'b1, 4'd0);
        step();
        chk_all("mr.done2", 4'b0100, 4'b0100, 1'b1, 4'd0);
        step();
        chk_all("mr.idle2", 4'b0000, 4'b0000, 1'b0, 4'd0);
        step();
        chk_all("mr.clear3", 4'b1000, 4'b0000, 1'b1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
